// File: rtl/eth_recv.sv
// eth_recv: 4-bit MII receive path. Locks on preamble/SFD, assembles bytes
// low nibble first, filters on destination MAC and EtherType, streams the
// payload (FCS included) into a byte buffer and reports one status pulse per
// frame.
module eth_recv #(
  parameter logic [47:0] MY_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETH_TYPE = 16'h88B5,
  parameter int          BUF_AW   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [3:0]        rxd,
  input  logic              rx_er,
  output logic [BUF_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              wr_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ok_o,
  output logic [10:0]       len_o,
  output logic [3:0]        err_o
);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_PRE, S_HDR, S_PAY} state_t;

  // Buffer capacity in bytes; one bit wider than the 11-bit counter so
  // BUF_AW = 11 still compares correctly.
  localparam logic [11:0] CAP = 12'(1) << BUF_AW;
  // Good-frame residue as seen MSB-first; the register itself is kept in
  // reflected (LSB-first) order, so it is bit-reversed before comparing.
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  state_t            state_q;
  logic [3:0]        pre_cnt_q;
  logic              phase_q;
  logic [3:0]        low_q;
  logic [7:0]        byte_q;
  logic              byte_vld_q;
  logic [10:0]       cnt_q;
  logic [31:0]       crc_q;
  logic              uni_miss_q;
  logic              bc_miss_q;
  logic              type_miss_q;
  logic              ovf_q;
  logic              er_q;
  logic              fin_q;
  logic              align_q;
  logic              runt_q;
  logic [BUF_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              ok_q;
  logic [10:0]       len_q;
  logic [3:0]        err_q;

  logic [31:0]       crc_d;
  logic [7:0]        exp_byte_d;
  logic              filter_d;
  logic              crc_bad_d;
  logic [10:0]       len_d;

  // One byte through the reflected CRC32 (poly 0xEDB88320).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) begin
      r[k] = v[31-k];
    end
    return r;
  endfunction

  // Next CRC, expected header byte for the current index, and end-of-frame status terms.
  always_comb begin
    crc_d      = crc_step(crc_q, byte_q);
    filter_d   = (uni_miss_q & bc_miss_q) | type_miss_q;
    crc_bad_d  = (bit_rev(crc_q) != RESIDUE) | runt_q | er_q;
    len_d      = (cnt_q >= 11'd4) ? (cnt_q - 11'd4) : 11'd0;
    exp_byte_d = 8'h00;
    case (cnt_q[3:0])
      4'd0:    exp_byte_d = MY_MAC[47:40];
      4'd1:    exp_byte_d = MY_MAC[39:32];
      4'd2:    exp_byte_d = MY_MAC[31:24];
      4'd3:    exp_byte_d = MY_MAC[23:16];
      4'd4:    exp_byte_d = MY_MAC[15:8];
      4'd5:    exp_byte_d = MY_MAC[7:0];
      4'd12:   exp_byte_d = ETH_TYPE[15:8];
      4'd13:   exp_byte_d = ETH_TYPE[7:0];
      default: exp_byte_d = 8'h00;
    endcase
  end

  // Receive FSM: lock, byte assembly, header filter, payload writes, status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      pre_cnt_q   <= 4'd0;
      phase_q     <= 1'b0;
      low_q       <= 4'd0;
      byte_q      <= 8'd0;
      byte_vld_q  <= 1'b0;
      cnt_q       <= 11'd0;
      crc_q       <= 32'hFFFF_FFFF;
      uni_miss_q  <= 1'b0;
      bc_miss_q   <= 1'b0;
      type_miss_q <= 1'b0;
      ovf_q       <= 1'b0;
      er_q        <= 1'b0;
      fin_q       <= 1'b0;
      align_q     <= 1'b0;
      runt_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      len_q       <= 11'd0;
      err_q       <= 4'd0;
    end else begin
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      byte_vld_q <= 1'b0;

      // A byte assembled last cycle is consumed now, including on the
      // cycle where rx_dv falls.
      if (byte_vld_q && (state_q == S_HDR || state_q == S_PAY)) begin
        crc_q <= crc_d;
        if (state_q == S_HDR) begin
          if (cnt_q < 11'd6) begin
            if (byte_q != exp_byte_d) uni_miss_q <= 1'b1;
            if (byte_q != 8'hFF)      bc_miss_q  <= 1'b1;
          end
          if ((cnt_q == 11'd12 || cnt_q == 11'd13) && byte_q != exp_byte_d) begin
            type_miss_q <= 1'b1;
          end
          if (cnt_q == 11'd13) begin
            cnt_q   <= 11'd0;
            state_q <= S_PAY;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end else begin
          if (!filter_d) begin
            if ({1'b0, cnt_q} < CAP) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[BUF_AW-1:0];
              wr_data_q <= byte_q;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
        end
      end

      // Status pulse one cycle after the frame end, once the last byte is in.
      if (fin_q) begin
        fin_q  <= 1'b0;
        done_q <= 1'b1;
        busy_q <= 1'b0;
        len_q  <= len_d;
        err_q  <= {align_q, ovf_q, filter_d, crc_bad_d};
        ok_q   <= ~(align_q | ovf_q | filter_d | crc_bad_d);
      end

      case (state_q)
        S_SYNC: begin
          // The rx_dv fall that ended a frame already proves the line is quiet.
          if (!rx_dv || fin_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (rx_dv) begin
            if (rxd == 4'h5 && !rx_er) begin
              state_q   <= S_PRE;
              pre_cnt_q <= 4'd1;
            end else begin
              state_q <= S_SYNC;
            end
          end
        end
        S_PRE: begin
          if (!rx_dv || rx_er) begin
            state_q <= S_SYNC;
          end else if (rxd == 4'h5) begin
            if (pre_cnt_q != 4'd15) pre_cnt_q <= pre_cnt_q + 4'd1;
          end else if (rxd == 4'hD && pre_cnt_q >= 4'd2) begin
            state_q     <= S_HDR;
            busy_q      <= 1'b1;
            crc_q       <= 32'hFFFF_FFFF;
            cnt_q       <= 11'd0;
            phase_q     <= 1'b0;
            uni_miss_q  <= 1'b0;
            bc_miss_q   <= 1'b0;
            type_miss_q <= 1'b0;
            ovf_q       <= 1'b0;
            er_q        <= 1'b0;
          end else begin
            state_q <= S_SYNC;
          end
        end
        S_HDR, S_PAY: begin
          if (!rx_dv) begin
            state_q <= S_SYNC;
            fin_q   <= 1'b1;
            align_q <= phase_q;
            // Runt: header never completed, counting the byte consumed now.
            runt_q  <= (state_q == S_HDR) && !(byte_vld_q && cnt_q == 11'd13);
          end else begin
            if (rx_er) er_q <= 1'b1;
            if (!phase_q) begin
              low_q   <= rxd;
              phase_q <= 1'b1;
            end else begin
              byte_q     <= {rxd, low_q};
              byte_vld_q <= 1'b1;
              phase_q    <= 1'b0;
            end
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_en_o   = wr_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ok_o      = ok_q;
  assign len_o     = len_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_eth_recv.sv
// tb_eth_recv: drives MII nibble streams into eth_recv and compares buffer
// writes and status pulses against a frame-level model.
module tb_eth_recv;

  localparam logic [47:0] MY_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST    = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETH_TYPE = 16'h88B5;
  localparam int          BUF_AW   = 9;

  typedef struct packed {
    logic        ok;
    logic [10:0] len;
    logic [3:0]  err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_dv;
  logic [3:0]        rxd;
  logic              rx_er;
  logic [BUF_AW-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;
  logic              wr_en_o;
  logic              busy_o;
  logic              done_o;
  logic              ok_o;
  logic [10:0]       len_o;
  logic [3:0]        err_o;

  int n_checks = 0;
  int n_errors = 0;
  int busy_at_done = 0;
  bit busy_seen = 0;

  logic [7:0]         frm[$];
  res_t               got_r[$];
  res_t               exp_r[$];
  logic [BUF_AW+7:0]  got_w[$];
  logic [BUF_AW+7:0]  exp_w[$];

  eth_recv #(.MY_MAC(MY_MAC), .ETH_TYPE(ETH_TYPE), .BUF_AW(BUF_AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
    .busy_o(busy_o), .done_o(done_o), .ok_o(ok_o), .len_o(len_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Capture writes and status pulses on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_o) got_w.push_back({wr_addr_o, wr_data_o});
      if (done_o) begin
        got_r.push_back('{ok: ok_o, len: len_o, err: err_o});
        if (busy_o) busy_at_done++;
      end
      if (busy_o) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic dv, input logic [3:0] d, input logic er);
    @(negedge clk);
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b0, 4'h0, 1'b0);
  endtask

  // Reference CRC32 over frm[0..cnt-1], bit-serial, returns the FCS value.
  function automatic logic [31:0] crc32_of(input int cnt);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      b = frm[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // Frame = dest, random src, type, n random data bytes, FCS (LSB first).
  task automatic build_frame(input logic [47:0] dest, input logic [15:0] etype, input int n);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom()));
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom()));
    fcs = crc32_of(frm.size());
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  // Expected writes and status for frm as it will appear on the wire.
  task automatic model_expect(input bit odd, input bit er);
    logic [47:0] dest;
    logic [15:0] etype;
    logic [31:0] fcs_rx;
    bit          filt, ovf, crc_bad;
    int          n, npay;
    res_t        r;
    n = frm.size();
    dest = '0;
    for (int i = 0; i < 6; i++) dest = {dest[39:0], frm[i]};
    etype  = {frm[12], frm[13]};
    filt   = !((dest == MY_MAC) || (dest == BCAST)) || (etype != ETH_TYPE);
    npay   = n - 14;
    fcs_rx = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
    crc_bad = (crc32_of(n - 4) != fcs_rx) || er;
    ovf    = !filt && (npay > (1 << BUF_AW));
    if (!filt) begin
      for (int i = 0; i < npay && i < (1 << BUF_AW); i++) begin
        exp_w.push_back({BUF_AW'(i), frm[14+i]});
      end
    end
    r.len = (npay >= 4) ? 11'(npay - 4) : 11'd0;
    r.err = {odd, ovf, filt, crc_bad};
    r.ok  = (r.err == 4'd0);
    exp_r.push_back(r);
  endtask

  task automatic send_frame(input int npre, input bit odd, input int gap, input int er_nib);
    logic [7:0] b;
    int k;
    for (int i = 0; i < npre; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    k = 0;
    foreach (frm[i]) begin
      b = frm[i];
      nib(1'b1, b[3:0], k == er_nib);
      k++;
      nib(1'b1, b[7:4], k == er_nib);
      k++;
    end
    if (odd) nib(1'b1, 4'($urandom()), 1'b0);
    idle(gap);
  endtask

  task automatic compare_batch(input string tag);
    int nr, nw;
    chk({tag, " status count"}, got_r.size(), exp_r.size());
    nr = (got_r.size() < exp_r.size()) ? got_r.size() : exp_r.size();
    for (int i = 0; i < nr; i++) begin
      chk($sformatf("%s r%0d ok", tag, i), got_r[i].ok, exp_r[i].ok);
      chk($sformatf("%s r%0d len", tag, i), got_r[i].len, exp_r[i].len);
      chk($sformatf("%s r%0d err", tag, i), got_r[i].err, exp_r[i].err);
    end
    chk({tag, " write count"}, got_w.size(), exp_w.size());
    nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s w%0d addr/data", tag, i), got_w[i], exp_w[i]);
    end
    $display("frame %s: %0d status, %0d writes", tag, got_r.size(), got_w.size());
    got_r.delete(); exp_r.delete(); got_w.delete(); exp_w.delete();
  endtask

  initial begin
    logic [63:0] t;
    logic [47:0] d;
    logic [15:0] ty;
    bit          odd, flip;

    rst_n = 1'b0; rx_dv = 1'b0; rxd = 4'h0; rx_er = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset wr_en", wr_en_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset ok", ok_o, 0);
    chk("reset len", len_o, 0);
    chk("reset err", err_o, 0);
    rst_n = 1'b1;
    idle(3);

    // Good unicast frame, 20-byte payload.
    build_frame(MY_MAC, ETH_TYPE, 20);
    model_expect(0, 0);
    busy_seen = 0;
    send_frame(7, 0, 6, -1);
    chk("good busy seen", busy_seen, 1);
    if (got_r.size() > 0) begin
      chk("good len 20", got_r[0].len, 20);
      chk("good err 0", got_r[0].err, 0);
    end
    compare_batch("good");

    // One payload bit flipped after the FCS was computed.
    build_frame(MY_MAC, ETH_TYPE, 20);
    frm[20] = frm[20] ^ 8'h04;
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    if (got_r.size() > 0) chk("flip err 0001", got_r[0].err, 4'b0001);
    compare_batch("flip");

    // Foreign unicast destination.
    build_frame(48'h02_00_00_00_00_02, ETH_TYPE, 20);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    if (got_r.size() > 0) chk("other err 0010", got_r[0].err, 4'b0010);
    compare_batch("other_mac");

    build_frame(BCAST, ETH_TYPE, 16);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    compare_batch("broadcast");

    build_frame(MY_MAC, 16'h0800, 16);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    compare_batch("bad_type");

    // 518 data + 4 FCS = 2^BUF_AW + 10 bytes into the buffer path.
    build_frame(MY_MAC, ETH_TYPE, 518);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    if (got_r.size() > 0) begin
      chk("ovf len 518", got_r[0].len, 518);
      chk("ovf err2", got_r[0].err[2], 1);
    end
    compare_batch("overflow");

    build_frame(MY_MAC, ETH_TYPE, 12);
    model_expect(1, 0);
    send_frame(7, 1, 6, -1);
    compare_batch("odd_nibble");

    build_frame(MY_MAC, ETH_TYPE, 12);
    model_expect(0, 1);
    send_frame(7, 0, 6, 40);
    compare_batch("rx_er");

    // Reset mid-payload, released while rx_dv stays high through a whole
    // further frame; nothing may be reported.
    build_frame(MY_MAC, ETH_TYPE, 30);
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      nib(1'b1, frm[i][3:0], 1'b0);
      nib(1'b1, frm[i][7:4], 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy_o, 0);
    chk("async rst wr_en", wr_en_o, 0);
    got_r.delete(); got_w.delete();
    for (int i = 20; i < 22; i++) begin
      nib(1'b1, frm[i][3:0], 1'b0);
      nib(1'b1, frm[i][7:4], 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 22; i < frm.size(); i++) begin
      nib(1'b1, frm[i][3:0], 1'b0);
      nib(1'b1, frm[i][7:4], 1'b0);
    end
    build_frame(MY_MAC, ETH_TYPE, 10);
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    foreach (frm[i]) begin
      nib(1'b1, frm[i][3:0], 1'b0);
      nib(1'b1, frm[i][7:4], 1'b0);
    end
    idle(6);
    compare_batch("reset_mid");

    build_frame(MY_MAC, ETH_TYPE, 20);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    compare_batch("after_reset");

    // Short preamble 5,5,7 with rx_dv held high into a later valid-looking SFD.
    busy_seen = 0;
    nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 40; i++) nib(1'b1, 4'($urandom()), 1'b0);
    idle(6);
    chk("pre557 busy seen", busy_seen, 0);
    compare_batch("pre_557");

    // Two valid frames separated by a single idle cycle.
    build_frame(MY_MAC, ETH_TYPE, 20);
    model_expect(0, 0);
    send_frame(7, 0, 1, -1);
    build_frame(MY_MAC, ETH_TYPE, 24);
    model_expect(0, 0);
    send_frame(7, 0, 6, -1);
    compare_batch("back2back");

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0, 1: d = MY_MAC;
        2:    d = BCAST;
        default: begin
          t = {$urandom(), $urandom()};
          d = t[47:0];
          if (d == MY_MAC || d == BCAST) d[0] = ~d[0];
        end
      endcase
      ty   = ($urandom_range(0, 4) == 0) ? 16'($urandom()) : ETH_TYPE;
      odd  = ($urandom_range(0, 3) == 0);
      flip = ($urandom_range(0, 3) == 0);
      build_frame(d, ty, $urandom_range(0, 40));
      if (flip) begin
        int p;
        p = $urandom_range(0, frm.size() - 1);
        frm[p] = frm[p] ^ (8'h01 << $urandom_range(0, 7));
      end
      model_expect(odd, 0);
      send_frame($urandom_range(3, 7), odd, $urandom_range(1, 4), -1);
    end
    idle(6);
    compare_batch("random");

    chk("busy low during done", busy_at_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
